alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arbiter.sv | 88 ++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels plus the link to the shared ALU.
// The arbiter uses the slave modport; requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
  parameter int DATA_WID = 32
);
  logic                req0;
  logic                req1;
  logic [1:0]          fun0;
  logic [1:0]          fun1;
  logic [DATA_WID-1:0] a0;
  logic [DATA_WID-1:0] a1;
  logic [DATA_WID-1:0] b0;
  logic [DATA_WID-1:0] b1;
  logic                setc0;
  logic                setc1;
  logic                ack0;
  logic                ack1;
  logic                done0;
  logic                done1;
  logic [DATA_WID-1:0] result;
  logic                busy;
  logic [1:0]          alu_fun;
  logic [DATA_WID-1:0] alu_a;
  logic [DATA_WID-1:0] alu_b;
  logic                alu_set_cond;
  logic [DATA_WID-1:0] alu_valE;

  modport slave (
    input  req0, req1, fun0, fun1, a0, a1, b0, b1, setc0, setc1, alu_valE,
    output ack0, ack1, done0, done1, result, busy,
           alu_fun, alu_a, alu_b, alu_set_cond
  );

  modport master (
    output req0, req1, fun0, fun1, a0, a1, b0, b1, setc0, setc1, alu_valE,
    input  ack0, ack1, done0, done1, result, busy,
           alu_fun, alu_a, alu_b, alu_set_cond
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// Each operation runs IDLE(grant) -> ISSUE(drive ALU) -> RESP(done), one cycle each.
module alu_arbiter #(
  parameter int DATA_WID = 32
) (
  input logic         CLK,
  input logic         RST,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                grant0;
  logic                grant1;
  logic                last_q;   // requester served most recently
  logic                owner_q;  // requester owning the operation in flight
  logic [1:0]          fun_q;
  logic [DATA_WID-1:0] a_q;
  logic [DATA_WID-1:0] b_q;
  logic                setc_q;
  logic [DATA_WID-1:0] result_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (bus.req0 && (!bus.req1 || last_q)) grant0 = 1'b1;
        else if (bus.req1)                     grant1 = 1'b1;
        if (grant0 || grant1) state_d = ISSUE;
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      fun_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      setc_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        last_q  <= grant1;
        owner_q <= grant1;
        fun_q   <= grant1 ? bus.fun1  : bus.fun0;
        a_q     <= grant1 ? bus.a1    : bus.a0;
        b_q     <= grant1 ? bus.b1    : bus.b0;
        setc_q  <= grant1 ? bus.setc1 : bus.setc0;
      end
      if (state_q == ISSUE) result_q <= bus.alu_valE;
    end
  end

  // Handshake pulses are masked by RST so a reset cycle never acknowledges or completes.
  assign bus.ack0  = grant0 && !RST;
  assign bus.ack1  = grant1 && !RST;
  assign bus.done0 = (state_q == RESP) && !owner_q && !RST;
  assign bus.done1 = (state_q == RESP) &&  owner_q && !RST;
  assign bus.busy  = (state_q != IDLE);
  assign bus.result = result_q;

  // ALU operands follow the latched copy, so they only move on a grant.
  assign bus.alu_fun      = fun_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_set_cond = (state_q == ISSUE) && setc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester operations plus
// hand-written tie, late-arrival, reset-abort and back-to-back sequences.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam logic [1:0] F_ADD = 2'd0;
  localparam logic [1:0] F_SUB = 2'd1;
  localparam logic [1:0] F_AND = 2'd2;
  localparam logic [1:0] F_OR  = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [1:0] cc_q;   // {zero, sign} flags of the modelled shared ALU

  alu_arbiter_if #(.DATA_WID(DW)) bus ();

  alu_arbiter #(.DATA_WID(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Shared ALU model: combinational result, flags updated on set_cond.
  always_comb begin
    case (bus.alu_fun)
      F_ADD:   bus.alu_valE = bus.alu_b + bus.alu_a;
      F_SUB:   bus.alu_valE = bus.alu_b - bus.alu_a;
      F_AND:   bus.alu_valE = bus.alu_b & bus.alu_a;
      default: bus.alu_valE = bus.alu_b | bus.alu_a;
    endcase
  end

  always @(posedge CLK) begin
    if (RST)                   cc_q <= 2'b00;
    else if (bus.alu_set_cond) cc_q <= {bus.alu_valE == '0, bus.alu_valE[DW-1]};
  end

  typedef struct {
    int         who;
    logic [1:0] fun;
    logic [31:0] a;
    logic [31:0] b;
    logic       setc;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic drive(input int who, input logic req, input logic [1:0] fun,
                       input logic [31:0] a, input logic [31:0] b, input logic setc);
    if (who == 0) begin
      bus.req0 = req; bus.fun0 = fun; bus.a0 = a; bus.b0 = b; bus.setc0 = setc;
    end else begin
      bus.req1 = req; bus.fun1 = fun; bus.a1 = a; bus.b1 = b; bus.setc1 = setc;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [1:0] cc_exp;
    logic ack_w, ack_o, done_w, done_o;
    v = vecs[i];
    cc_exp = v.setc ? {v.res == 32'd0, v.res[31]} : cc_q;
    step();
    drive(v.who, 1'b1, v.fun, v.a, v.b, v.setc);
    mid();
    ack_w = (v.who == 0) ? bus.ack0 : bus.ack1;
    ack_o = (v.who == 0) ? bus.ack1 : bus.ack0;
    check($sformatf("vec%0d ack", i), {ack_w, ack_o}, 2'b10);
    step();
    drive(v.who, 1'b0, v.fun, v.a, v.b, v.setc);
    mid();
    check($sformatf("vec%0d set_cond", i), bus.alu_set_cond, v.setc);
    check($sformatf("vec%0d alu_ops", i), {bus.alu_fun, bus.alu_a, bus.alu_b}, {v.fun, v.a, v.b});
    step();
    mid();
    done_w = (v.who == 0) ? bus.done0 : bus.done1;
    done_o = (v.who == 0) ? bus.done1 : bus.done0;
    check($sformatf("vec%0d done", i), {done_w, done_o, bus.alu_set_cond}, 3'b100);
    check($sformatf("vec%0d result", i), bus.result, v.res);
    step();
    mid();
    check($sformatf("vec%0d idle", i), {bus.busy, bus.done0, bus.done1}, 3'b000);
    check($sformatf("vec%0d cc", i), cc_q, cc_exp);
  endtask

  initial begin
    vecs[0] = '{0, F_ADD, 32'd5,        32'd7,        1'b1, 32'd12};
    vecs[1] = '{1, F_SUB, 32'd3,        32'd10,       1'b0, 32'd7};
    vecs[2] = '{0, F_AND, 32'hF0,       32'h3C,       1'b1, 32'h30};
    vecs[3] = '{1, F_OR,  32'h0F,       32'hF0,       1'b1, 32'hFF};
    vecs[4] = '{0, F_SUB, 32'd10,       32'd3,        1'b1, 32'hFFFF_FFF9};
    vecs[5] = '{1, F_ADD, 32'hFFFF_FFFF, 32'd1,       1'b1, 32'd0};
    vecs[6] = '{0, F_AND, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'd0};

    drive(0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    RST = 1'b1;
    step(); step();
    mid();
    check("reset outputs", {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.busy, bus.alu_set_cond}, 6'b0);
    check("reset regs", {bus.result, bus.alu_fun, bus.alu_a, bus.alu_b}, '0);
    step();
    RST = 1'b0;
    mid();
    check("idle no req", {bus.ack0, bus.ack1, bus.busy}, 3'b000);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Tie after reset: requester 0 first, requester 1 three cycles later.
    RST = 1'b1; step(); RST = 1'b0;
    drive(0, 1'b1, F_ADD, 32'd1, 32'd2, 1'b0);
    drive(1, 1'b1, F_ADD, 32'd10, 32'd20, 1'b0);
    mid();
    check("tie ack T", {bus.ack0, bus.ack1}, 2'b10);
    step(); bus.req0 = 1'b0;
    mid();
    check("tie T+1 no ack", {bus.ack0, bus.ack1, bus.busy}, 3'b001);
    step(); mid();
    check("tie done0 T+2", {bus.done0, bus.done1, bus.ack1}, 3'b100);
    check("tie result0", bus.result, 32'd3);
    step(); mid();
    check("tie ack1 T+3", {bus.ack0, bus.ack1}, 2'b01);
    step(); bus.req1 = 1'b0;
    mid();
    step(); mid();
    check("tie done1 T+5", {bus.done0, bus.done1}, 2'b01);
    check("tie result1", bus.result, 32'd30);
    step();

    // Request from 0 arriving during requester 1's ISSUE waits for IDLE.
    drive(1, 1'b1, F_SUB, 32'd4, 32'd9, 1'b0);
    mid();
    check("late ack1", bus.ack1, 1'b1);
    step();
    bus.req1 = 1'b0;
    drive(0, 1'b1, F_OR, 32'h1, 32'h2, 1'b0);
    mid();
    check("late no ack0 in ISSUE", bus.ack0, 1'b0);
    step(); mid();
    check("late done1 no ack0", {bus.done1, bus.ack0}, 2'b10);
    check("late result1", bus.result, 32'd5);
    step(); mid();
    check("late ack0 after done1", bus.ack0, 1'b1);
    step(); bus.req0 = 1'b0;
    step(); mid();
    check("late done0", {bus.done0, bus.result}, {1'b1, 32'd3});
    step();

    // Reset during ISSUE aborts; next tie goes to requester 0; dropped req1 withdrawn.
    drive(1, 1'b1, F_ADD, 32'd1, 32'd1, 1'b0);
    mid();
    check("abort pre ack1", bus.ack1, 1'b1);
    step(); bus.req1 = 1'b0; step(); step(); step();
    drive(0, 1'b1, F_AND, 32'hF0, 32'h3C, 1'b1);
    mid();
    check("abort ack0", bus.ack0, 1'b1);
    step();
    bus.req0 = 1'b0;
    RST = 1'b1;
    mid();
    check("abort issue set_cond", bus.alu_set_cond, 1'b1);
    step();
    RST = 1'b0;
    mid();
    check("abort no done", {bus.done0, bus.done1, bus.busy, bus.alu_set_cond}, 4'b0);
    check("abort result cleared", bus.result, 32'd0);
    step();
    drive(0, 1'b1, F_ADD, 32'd2, 32'd2, 1'b0);
    drive(1, 1'b1, F_ADD, 32'd3, 32'd3, 1'b0);
    mid();
    check("abort tie to 0", {bus.ack0, bus.ack1}, 2'b10);
    step(); bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(); mid();
    check("abort done0", {bus.done0, bus.result}, {1'b1, 32'd4});
    step(); mid();
    check("withdrawn req1", {bus.ack1, bus.busy}, 2'b00);

    // Back-to-back: requester 0 held high gets an ack every third cycle.
    step();
    drive(0, 1'b1, F_OR, 32'h0F, 32'hF0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mid();
      check($sformatf("b2b ack%0d", k), {bus.ack0, bus.busy}, 2'b10);
      step(); mid();
      check($sformatf("b2b hold%0d", k), {bus.ack0, bus.busy}, 2'b01);
      step(); mid();
      check($sformatf("b2b done%0d", k), {bus.done0, bus.ack0, bus.result}, {2'b10, 32'hFF});
      step();
    end
    bus.req0 = 1'b0;
    mid();
    check("b2b released", {bus.ack0, bus.busy}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
